// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, command and
// response byte constants, and the frame parity helper.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK_CHK   = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND  = 8'hFE;

    // PS/2 uses odd parity over the eight data bits.
    function automatic logic oddParity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Two-flop synchronizer plus 8-sample history for one PS/2 pad; pulses shorter
// than four clk cycles never form an edge pattern.
module ps2_host_tx_line_filter (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pad,
    output logic o_level,
    output logic o_fall_edge,
    output logic o_rise_edge,
    output logic o_is_high
);

    logic [1:0] r_sync;
    logic [7:0] r_history;

    // The idle bus is pulled up, so reset fills the pipeline with ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync    <= 2'b11;
            r_history <= 8'hFF;
        end else begin
            r_sync    <= {r_sync[0], i_pad};
            r_history <= {r_history[6:0], r_sync[1]};
        end
    end

    assign o_level     = r_sync[1];
    assign o_fall_edge = (r_history == 8'b1111_0000);
    assign o_rise_edge = (r_history == 8'b0000_1111);
    assign o_is_high   = &r_history;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts
// one command byte out on device-generated clock edges and checks the ACK bit.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5500,
    parameter int REQ_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    output logic       o_tx_done,
    output logic       o_tx_error,
    output logic       o_rx_inhibit,
    input  logic       i_key_clk_in,
    input  logic       i_key_data_in,
    output logic       o_key_clk_oe,
    output logic       o_key_data_oe
);

    localparam logic [12:0] INHIBIT_LAST  = 13'(INHIBIT_CYCLES - 1);
    localparam logic [12:0] REQ_LAST      = 13'(REQ_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LIMIT = 20'(TIMEOUT_CYCLES);
    localparam logic [3:0]  ACK_IDX       = 4'd10;

    state_t      r_state;
    state_t      w_nextState;
    logic [12:0] r_phaseCnt;
    logic [19:0] r_timeoutCnt;
    logic [9:0]  r_frame;
    logic [3:0]  r_bitIdx;
    logic        r_dataOe;
    logic        r_nack;

    logic w_clkLevel, w_clkFall, w_clkRise, w_clkHigh;
    logic w_dataLevel, w_dataFall, w_dataRise, w_dataHigh;
    logic w_timeout;
    logic w_unused;

    ps2_host_tx_line_filter u_clkFilter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_pad      (i_key_clk_in),
        .o_level    (w_clkLevel),
        .o_fall_edge(w_clkFall),
        .o_rise_edge(w_clkRise),
        .o_is_high  (w_clkHigh)
    );

    ps2_host_tx_line_filter u_dataFilter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_pad      (i_key_data_in),
        .o_level    (w_dataLevel),
        .o_fall_edge(w_dataFall),
        .o_rise_edge(w_dataRise),
        .o_is_high  (w_dataHigh)
    );

    assign w_unused = ^{w_clkLevel, w_clkRise, w_dataFall, w_dataRise};

    assign w_timeout = (r_state inside {ST_SEND, ST_ACK_CHK, ST_WAIT_IDLE}) &&
                       (r_timeoutCnt == TIMEOUT_LIMIT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The timeout is checked before any edge so a stalled device always ends in an error.
    always_comb begin
        w_nextState = r_state;
        o_tx_done   = 1'b0;
        o_tx_error  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_tx_valid) w_nextState = ST_INHIBIT;
            end
            ST_INHIBIT: begin
                if (r_phaseCnt == INHIBIT_LAST) w_nextState = ST_REQ;
            end
            ST_REQ: begin
                if (r_phaseCnt == REQ_LAST) w_nextState = ST_SEND;
            end
            ST_SEND: begin
                if (w_timeout) begin
                    o_tx_error  = 1'b1;
                    w_nextState = ST_IDLE;
                end else if (w_clkFall && r_bitIdx == ACK_IDX) begin
                    w_nextState = ST_ACK_CHK;
                end
            end
            ST_ACK_CHK: begin
                if (w_timeout) begin
                    o_tx_error  = 1'b1;
                    w_nextState = ST_IDLE;
                end else if (w_clkFall) begin
                    w_nextState = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (w_timeout) begin
                    o_tx_error  = 1'b1;
                    w_nextState = ST_IDLE;
                end else if (w_clkHigh && w_dataHigh) begin
                    o_tx_done   = ~r_nack;
                    o_tx_error  = r_nack;
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // The start bit is already on the bus from REQ, so the first falling edge presents data bit 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phaseCnt   <= '0;
            r_timeoutCnt <= '0;
            r_frame      <= '0;
            r_bitIdx     <= '0;
            r_dataOe     <= 1'b0;
            r_nack       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_tx_valid) begin
                        r_frame    <= {1'b1, oddParity(i_tx_data), i_tx_data};
                        r_phaseCnt <= '0;
                        r_nack     <= 1'b0;
                    end
                end
                ST_INHIBIT, ST_REQ: begin
                    if (w_nextState != r_state) begin
                        r_phaseCnt   <= '0;
                        r_timeoutCnt <= '0;
                        r_bitIdx     <= '0;
                        r_dataOe     <= 1'b1;
                    end else begin
                        r_phaseCnt <= r_phaseCnt + 13'd1;
                    end
                end
                ST_SEND: begin
                    if (r_timeoutCnt != TIMEOUT_LIMIT) r_timeoutCnt <= r_timeoutCnt + 20'd1;
                    if (w_clkFall && r_bitIdx != ACK_IDX) begin
                        r_dataOe <= ~r_frame[r_bitIdx];
                        r_bitIdx <= r_bitIdx + 4'd1;
                    end
                end
                ST_ACK_CHK: begin
                    if (r_timeoutCnt != TIMEOUT_LIMIT) r_timeoutCnt <= r_timeoutCnt + 20'd1;
                    if (w_clkFall) r_nack <= w_dataLevel;
                end
                ST_WAIT_IDLE: begin
                    if (r_timeoutCnt != TIMEOUT_LIMIT) r_timeoutCnt <= r_timeoutCnt + 20'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_tx_ready    = (r_state == ST_IDLE);
    assign o_rx_inhibit  = (r_state != ST_IDLE);
    assign o_key_clk_oe  = (r_state == ST_INHIBIT) || (r_state == ST_REQ);
    assign o_key_data_oe = (r_state == ST_REQ) || ((r_state == ST_SEND) && r_dataOe);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host while a
// scoreboard matches every tx_done/tx_error pulse against queued expectations.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH = 200;
    localparam int REQ = 16;
    localparam int TMO = 3000;
    localparam int H   = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txValid = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       txReady, txDone, txError, rxInhibit, keyClkOe, keyDataOe;
    logic       devClkLow = 1'b0;
    logic       devDataLow = 1'b0;
    logic       clkLine, dataLine;

    int testsRun = 0;
    int testsFailed = 0;
    logic [10:0] frameQ[$];
    int          resultQ[$];

    assign clkLine  = ~(keyClkOe | devClkLow);
    assign dataLine = ~(keyDataOe | devDataLow);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .REQ_CYCLES    (REQ),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tx_valid   (txValid),
        .i_tx_data    (txData),
        .o_tx_ready   (txReady),
        .o_tx_done    (txDone),
        .o_tx_error   (txError),
        .o_rx_inhibit (rxInhibit),
        .i_key_clk_in (clkLine),
        .i_key_data_in(dataLine),
        .o_key_clk_oe (keyClkOe),
        .o_key_data_oe(keyDataOe)
    );

    // Bits as the device sees them on the wire: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] refFrame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every completion pulse must match the oldest queued expectation (0 done, 1 error).
    always @(negedge clk) begin
        if (txDone || txError) begin
            checkOutput("done_error_exclusive", 32'(txDone & txError), 32'd0);
            if (resultQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_pulse: got done=%0b error=%0b, expected none", txDone, txError);
            end else begin
                checkOutput("result_kind", 32'(txError), 32'(resultQ.pop_front()));
            end
        end
    end

    task automatic deviceRun(input bit ack, input int glitchAt, input int abortAt, input bit silent);
        int          w;
        int          cnt;
        logic [10:0] rx;
        w  = 0;
        rx = '0;
        while (!(clkLine && !dataLine) && w < INH + REQ + 100) begin
            @(negedge clk);
            w++;
        end
        checkOutput("clock_released", 32'({clkLine, dataLine}), 32'b10);
        if (!(clkLine && !dataLine)) return;
        if (silent) begin
            checkOutput("clk_oe_at_release", 32'(keyClkOe), 32'd0);
            cnt = 0;
            while (!txError && cnt < TMO + 100) begin
                @(negedge clk);
                cnt++;
            end
            checkOutput("timeout_cycles", 32'(cnt), 32'(TMO));
            @(negedge clk);
            checkOutput("lines_released_after_timeout", 32'({keyClkOe, keyDataOe}), 32'd0);
            return;
        end
        for (int j = 0; j < 12; j++) begin
            repeat (H / 2) @(negedge clk);
            if (j == glitchAt) begin
                devClkLow = 1'b1;
                repeat (3) @(negedge clk);
                devClkLow = 1'b0;
            end
            repeat (H / 2) @(negedge clk);
            if (j < 11) rx[j] = dataLine;
            if (j == 11 && ack) devDataLow = 1'b1;
            devClkLow = 1'b1;
            if (j == abortAt) begin
                repeat (H / 2) @(negedge clk);
                checkOutput("data_driven_before_abort", 32'(keyDataOe), 32'd1);
                rst = 1'b1;
                @(negedge clk);
                checkOutput("abort_state", 32'({txReady, txDone, txError, rxInhibit, keyClkOe, keyDataOe}),
                            32'b100000);
                rst = 1'b0;
                devClkLow = 1'b0;
                repeat (100) @(negedge clk);
                return;
            end
            repeat (H) @(negedge clk);
            devClkLow = 1'b0;
        end
        devDataLow = 1'b0;
        if (frameQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL frame_bits: got %03h, expected no frame", rx);
        end else begin
            checkOutput("frame_bits", 32'(rx), 32'(frameQ.pop_front()));
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input bit ack, input int glitchAt,
                                 input int abortAt, input bit silent, input bit pokeBusy);
        int waitCnt;
        waitCnt = 0;
        while (!txReady && waitCnt < 5000) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("ready_before_accept", 32'(txReady), 32'd1);
        txValid = 1'b1;
        txData  = d;
        if (!silent && abortAt < 0) frameQ.push_back(refFrame(d));
        if (abortAt < 0) resultQ.push_back((silent || !ack) ? 1 : 0);
        @(negedge clk);
        txValid = 1'b0;
        checkOutput("busy_after_accept", 32'({txReady, rxInhibit, keyClkOe, keyDataOe}), 32'b0110);
        if (pokeBusy) begin
            txValid = 1'b1;
            txData  = 8'hAA;
            repeat (20) @(negedge clk);
            txValid = 1'b0;
        end
        deviceRun(ack, glitchAt, abortAt, silent);
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waitCnt;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 32'({txReady, txDone, txError, rxInhibit, keyClkOe, keyDataOe}), 32'b100000);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("idle_after_reset", 32'({txReady, rxInhibit, keyClkOe, keyDataOe}), 32'b1000);

        applyStimulus(PS2_CMD_SET_LED, 1'b1, -1, -1, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b1, -1, -1, 1'b0, 1'b1);
        applyStimulus(PS2_CMD_RESET, 1'b1, -1, -1, 1'b0, 1'b0);
        applyStimulus(PS2_CMD_ENABLE, 1'b1, -1, -1, 1'b1, 1'b0);
        applyStimulus(8'h55, 1'b0, -1, -1, 1'b0, 1'b0);
        applyStimulus(8'h0F, 1'b1, -1, 4, 1'b0, 1'b0);
        applyStimulus(8'hA5, 1'b1, 4, -1, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            bit         ack;
            int         glitch;
            d      = 8'($urandom_range(0, 255));
            ack    = ($urandom_range(0, 3) != 0);
            glitch = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1;
            applyStimulus(d, ack, glitch, -1, 1'b0, 1'b0);
        end

        waitCnt = 0;
        while (!txReady && waitCnt < 5000) begin
            @(negedge clk);
            waitCnt++;
        end
        repeat (50) @(negedge clk);
        checkOutput("pending_results", 32'(resultQ.size()), 32'd0);
        checkOutput("pending_frames", 32'(frameQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
